// File: rtl/sv_motor_seq.sv
// sv_motor_seq: hobby-servo position controller.
// Manual jog vs 4-entry waypoint sequencer, slew-limited to 1 deg per tick.
module sv_motor_seq #(
  parameter int DIV_W       = 22,
  parameter int DWELL_TICKS = 8,
  parameter int DEG_MAX     = 180,
  parameter int DEG_HOME    = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic [1:0] speed,
  input  logic       wp_we,
  input  logic [1:0] wp_addr,
  input  logic [7:0] wp_data,
  input  logic [2:0] wp_cnt,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [7:0] deg,
  output logic [1:0] state,
  output logic       busy,
  output logic       done,
  output logic [1:0] wp_idx,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MANUAL = 2'd1,
    S_MOVE   = 2'd2,
    S_DWELL  = 2'd3
  } state_e;

  localparam int DT_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DWELL_TICKS - 1);
  localparam logic [7:0] MAX8  = 8'(DEG_MAX);
  localparam logic [7:0] HOME8 = 8'(DEG_HOME);

  state_e            state_q, state_d;
  logic [7:0]        deg_q, deg_d;
  logic [7:0]        tgt_q, tgt_d;
  logic [1:0]        idx_q, idx_d;
  logic [DT_W-1:0]   dwl_q, dwl_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [7:0]        wp_q [4];
  logic              tick, jog;
  logic [2:0]        eff_cnt, nxt_idx;

  assign tick    = cnt_q[DIV_W-1];
  assign jog     = inc | dec;
  assign eff_cnt = (wp_cnt > 3'd4) ? 3'd4 : wp_cnt;
  assign nxt_idx = {1'b0, idx_q} + 3'd1;

  // next-state, position stepping and sequencer bookkeeping
  always_comb begin
    state_d = state_q;
    deg_d   = deg_q;
    tgt_d   = tgt_q;
    idx_d   = idx_q;
    dwl_d   = dwl_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (jog) begin
          state_d = S_MANUAL;
        end else if (start && wp_cnt != 3'd0) begin
          state_d = S_MOVE;
          idx_d   = 2'd0;
          tgt_d   = wp_q[0];
          err_d   = 1'b0;
        end
      end
      S_MANUAL: begin
        if (!jog) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (inc) begin
            if (deg_q != MAX8) deg_d = deg_q + 8'd1;
          end else if (deg_q != 8'd0) begin
            deg_d = deg_q - 8'd1;
          end
        end
      end
      S_MOVE: begin
        if (jog) begin
          state_d = S_MANUAL;
          idx_d   = 2'd0;
        end else if (stop) begin
          state_d = S_IDLE;
        end else if (deg_q == tgt_q) begin
          state_d = S_DWELL;
          dwl_d   = '0;
        end else if (tick) begin
          deg_d = (tgt_q > deg_q) ? deg_q + 8'd1 : deg_q - 8'd1;
        end
      end
      S_DWELL: begin
        if (jog) begin
          state_d = S_MANUAL;
          idx_d   = 2'd0;
        end else if (stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (dwl_q != DT_LAST) begin
            dwl_d = dwl_q + DT_W'(1);
          end else if (nxt_idx < eff_cnt) begin
            state_d = S_MOVE;
            idx_d   = nxt_idx[1:0];
            tgt_d   = wp_q[nxt_idx[1:0]];
          end else if (loop) begin
            state_d = S_MOVE;
            idx_d   = 2'd0;
            tgt_d   = wp_q[0];
          end else begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (wp_we && wp_data > MAX8) err_d = 1'b1;
    busy_d = (state_d == S_MOVE) || (state_d == S_DWELL);
    if (state_d != state_q || state_q == S_IDLE || tick)
      cnt_d = '0;
    else
      cnt_d = cnt_q + DIV_W'(speed) + DIV_W'(1);
  end

  // FSM, position and tick-divider registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      deg_q   <= HOME8;
      tgt_q   <= HOME8;
      idx_q   <= 2'd0;
      dwl_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      deg_q   <= deg_d;
      tgt_q   <= tgt_d;
      idx_q   <= idx_d;
      dwl_q   <= dwl_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // waypoint table, clamped on write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) wp_q[i] <= HOME8;
    end else if (wp_we) begin
      wp_q[wp_addr] <= (wp_data > MAX8) ? MAX8 : wp_data;
    end
  end

  assign deg    = deg_q;
  assign state  = state_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wp_idx = idx_q;
  assign err    = err_q;

endmodule
